// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_seq_pkg;

    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Scan end points for each scan direction.
    localparam logic [SEL_W-1:0] START_SEL_LSB = 2'd0;
    localparam logic [SEL_W-1:0] END_SEL_LSB   = 2'd3;
    localparam logic [SEL_W-1:0] START_SEL_MSB = 2'd3;
    localparam logic [SEL_W-1:0] END_SEL_MSB   = 2'd0;

    function automatic logic [SEL_W-1:0] start_sel(input bit msb_first);
        return msb_first ? START_SEL_MSB : START_SEL_LSB;
    endfunction

    function automatic logic [SEL_W-1:0] end_sel(input bit msb_first);
        return msb_first ? END_SEL_MSB : END_SEL_LSB;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Word handshake plus mux-side scan outputs of the select sequencer.
// Latency: n/a (wiring only).
// Backpressure: o_ready gates word acceptance; i_hold freezes scan progress.
// slave modport = sequencer side, master modport = upstream/downstream driver side.
interface mux_sel_sequencer_if;
    import mux_seq_pkg::*;

    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              i_hold;
    logic [DATA_W-1:0] o_data;
    logic [SEL_W-1:0]  o_sel;
    logic              o_sel_valid;
    logic              o_last;
    logic              o_done;

    modport slave (
        input  i_data, i_valid, i_hold,
        output o_ready, o_data, o_sel, o_sel_valid, o_last, o_done
    );

    modport master (
        output i_data, i_valid, i_hold,
        input  o_ready, o_data, o_sel, o_sel_valid, o_last, o_done
    );

endinterface

// File: rtl/mux_1_to_4.sv
// Plain 4:1 bit mux driven by the select sequencer.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data (4-bit word), i_sel (2-bit select), o_y (selected bit).
module mux_1_to_4 (
    input  logic [3:0] i_data,
    input  logic [1:0] i_sel,
    output logic       o_y
);

    assign o_y = i_data[i_sel];

endmodule

// File: rtl/mux_sel_sequencer_sel_hold_counter.sv
// Counts hold cycles of one select position and pulses tc on the last one.
// Latency: tc is combinational in the cycle the count sits at CLKS_PER_SEL-1.
// Backpressure: enable low freezes the count; clear returns it to zero.
// Ports: clk, rst (sync, active-high), enable, clear, tc (terminal-count pulse).
module sel_hold_counter #(
    parameter int CLKS_PER_SEL = 1   // 1..255; 0 has no meaning
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tc
);

    // Wide enough to hold CLKS_PER_SEL itself, never narrower than 1 bit.
    localparam int CNT_W = ($clog2(CLKS_PER_SEL + 1) < 1) ? 1 : $clog2(CLKS_PER_SEL + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLKS_PER_SEL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && (cnt == TC_VAL);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Captures a 4-bit word and steps the 4:1 mux select through it, one position per CLKS_PER_SEL cycles.
// Latency: first select live the cycle after accept; o_done the cycle after the final select completes.
// Backpressure: o_ready low during a scan; i_hold high freezes counter and select.
// Ports: i_clk, i_rst (sync, active-high), bus (slave: word handshake in, o_data/o_sel/o_sel_valid/o_last/o_done out).
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int CLKS_PER_SEL = 1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mux_sel_sequencer_if.slave   bus
);

    localparam logic [SEL_W-1:0] START = start_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST  = end_sel(MSB_FIRST);

    state_t state_q, state_d;
    logic   accept;
    logic   scan_en;
    logic   tc;
    logic   final_step;

    assign accept     = (state_q == IDLE) && bus.i_valid && !i_rst;
    assign scan_en    = (state_q == SCAN) && !bus.i_hold;
    assign final_step = tc && (bus.o_sel == LAST);

    sel_hold_counter #(
        .CLKS_PER_SEL (CLKS_PER_SEL)
    ) u_hold_cnt (
        .clk    (i_clk),
        .rst    (i_rst),
        .enable (scan_en),
        .clear  (accept),
        .tc     (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = SCAN;
            SCAN:    if (final_step) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stepping past the final select wraps back to START in 2-bit arithmetic,
    // so the select rests at the start value while idle without a separate load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_data <= '0;
            bus.o_sel  <= START;
            bus.o_done <= 1'b0;
        end else begin
            bus.o_done <= final_step;
            if (accept) begin
                bus.o_data <= bus.i_data;
                bus.o_sel  <= START;
            end else if (tc) begin
                bus.o_sel  <= MSB_FIRST ? SEL_W'(bus.o_sel - 2'd1) : SEL_W'(bus.o_sel + 2'd1);
            end
        end
    end

    // Ready is masked during reset so nothing looks acceptable while inputs are ignored.
    assign bus.o_ready     = (state_q == IDLE) && !i_rst;
    assign bus.o_sel_valid = (state_q == SCAN);
    assign bus.o_last      = (state_q == SCAN) && (bus.o_sel == LAST);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Drives two sequencer instances (LSB-first x1, MSB-first x3) through directed steps.
// Latency: expected per-cycle scan positions queued at accept, checked on each falling edge.
// Backpressure: exercises i_hold, back-to-back words and valid during scan/reset.
module tb_mux_sel_sequencer;

    typedef struct {
        logic [3:0] word;
        logic [1:0] sel;
        logic       y;
        logic       last;
        logic       eow;
    } ent_t;

    localparam int          CPS [2] = '{1, 3};
    localparam bit          MSB [2] = '{1'b0, 1'b1};
    localparam logic [1:0]  STRT[2] = '{2'd0, 2'd3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    ent_t q [2][$];
    bit   done_due [2];

    mux_sel_sequencer_if if0 ();
    mux_sel_sequencer_if if1 ();
    logic y0, y1;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.CLKS_PER_SEL(1), .MSB_FIRST(1'b0)) dut0 (
        .i_clk (clk), .i_rst (rst), .bus (if0.slave));
    mux_sel_sequencer #(.CLKS_PER_SEL(3), .MSB_FIRST(1'b1)) dut1 (
        .i_clk (clk), .i_rst (rst), .bus (if1.slave));

    mux_1_to_4 mux0 (.i_data (if0.o_data), .i_sel (if0.o_sel), .o_y (y0));
    mux_1_to_4 mux1 (.i_data (if1.o_data), .i_sel (if1.o_sel), .o_y (y1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected scan trace for one accepted word, one entry per unheld cycle.
    task automatic push_word(input int d, input logic [3:0] w);
        ent_t e;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < CPS[d]; c++) begin
                e.word = w;
                e.sel  = MSB[d] ? 2'(3 - p) : 2'(p);
                e.y    = w[e.sel];
                e.last = (p == 3);
                e.eow  = (p == 3) && (c == CPS[d] - 1);
                q[d].push_back(e);
            end
        end
    endtask

    function automatic bit model_idle(input int d);
        return (q[d].size() == 0) && !done_due[d];
    endfunction

    task automatic mon(input int d, input logic [3:0] data, input logic [1:0] sel,
                       input logic sv, input logic last, input logic done,
                       input logic ready, input logic y, input logic hold);
        ent_t e;
        bit   idle;
        chk($sformatf("d%0d_done", d), {7'd0, done}, {7'd0, done_due[d]});
        done_due[d] = 1'b0;
        idle = (q[d].size() == 0);
        chk($sformatf("d%0d_sel_valid", d), {7'd0, sv}, {7'd0, !idle});
        chk($sformatf("d%0d_ready", d), {7'd0, ready}, {7'd0, idle && !rst});
        if (!idle) begin
            e = q[d][0];
            chk($sformatf("d%0d_sel", d), {6'd0, sel}, {6'd0, e.sel});
            chk($sformatf("d%0d_data", d), {4'd0, data}, {4'd0, e.word});
            chk($sformatf("d%0d_y", d), {7'd0, y}, {7'd0, e.y});
            chk($sformatf("d%0d_last", d), {7'd0, last}, {7'd0, e.last});
            if (!hold) begin
                void'(q[d].pop_front());
                if (e.eow) done_due[d] = 1'b1;
            end
        end else begin
            chk($sformatf("d%0d_idle_last", d), {7'd0, last}, 8'd0);
            chk($sformatf("d%0d_idle_sel", d), {6'd0, sel}, {6'd0, STRT[d]});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, if0.o_data, if0.o_sel, if0.o_sel_valid, if0.o_last, if0.o_done,
                if0.o_ready, y0, if0.i_hold);
            mon(1, if1.o_data, if1.o_sel, if1.o_sel_valid, if1.o_last, if1.o_done,
                if1.o_ready, y1, if1.i_hold);
        end
    end

    // Acceptance model: a word offered while the model is idle is taken at the next edge.
    always @(negedge clk) begin
        #1;
        if (mon_en && !rst) begin
            if (if0.i_valid && model_idle(0)) push_word(0, if0.i_data);
            if (if1.i_valid && model_idle(1)) push_word(1, if1.i_data);
        end
    end

    task automatic wait_sel0(input logic [1:0] v);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (if0.o_sel_valid === 1'b1 && if0.o_sel === v) seen = 1'b1;
        end
        chk("wait_sel0_timeout", {7'd0, seen}, 8'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (model_idle(0) && model_idle(1)) ok = 1'b1;
        end
        chk("wait_idle_timeout", {7'd0, ok}, 8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Valid offered during reset must not be captured.
        if0.i_data = 4'hF; if0.i_valid = 1'b1; if0.i_hold = 1'b0;
        if1.i_data = 4'hF; if1.i_valid = 1'b1; if1.i_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; if0.i_valid = 1'b0; if1.i_valid = 1'b0; mon_en = 1'b1;
        chk("rst_data0", {4'd0, if0.o_data}, 8'h00);
        chk("rst_data1", {4'd0, if1.o_data}, 8'h00);
        chk("rst_sel0", {6'd0, if0.o_sel}, 8'd0);
        chk("rst_sel1", {6'd0, if1.o_sel}, 8'd3);
        chk("rst_done0", {7'd0, if0.o_done}, 8'd0);

        // Single word, one cycle per select, LSB first.
        if0.i_data = 4'b1010; if0.i_valid = 1'b1;
        @(posedge clk); #1;
        if0.i_valid = 1'b0;
        wait_idle();

        // MSB first, three cycles per select.
        if1.i_data = 4'b0110; if1.i_valid = 1'b1;
        @(posedge clk); #1;
        if1.i_valid = 1'b0;
        wait_idle();

        // Valid held high: second word taken in the done cycle; data churn mid-scan ignored.
        if0.i_data = 4'b1100; if0.i_valid = 1'b1;
        @(posedge clk); #1;
        if0.i_data = 4'b0011;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #1;
                if (if0.o_done === 1'b1) seen = 1'b1;
            end
            chk("b2b_done_timeout", {7'd0, seen}, 8'd1);
        end
        @(posedge clk); #1;
        if0.i_valid = 1'b0;
        if0.i_data  = 4'b1111;
        wait_idle();

        // Hold five cycles while the select sits at 1.
        if0.i_data = 4'b1001; if0.i_valid = 1'b1;
        @(posedge clk); #1;
        if0.i_valid = 1'b0;
        wait_sel0(2'd1);
        if0.i_hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        if0.i_hold = 1'b0;
        wait_idle();

        // Reset mid-scan at select 2: abort with no done.
        if0.i_data = 4'b0111; if0.i_valid = 1'b1;
        @(posedge clk); #1;
        if0.i_valid = 1'b0;
        wait_sel0(2'd2);
        rst = 1'b1;
        @(negedge clk); #1;
        q[0].delete(); q[1].delete();
        done_due[0] = 1'b0; done_due[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_sel0", {6'd0, if0.o_sel}, 8'd0);
        chk("abort_data0", {4'd0, if0.o_data}, 8'h00);
        chk("abort_sv0", {7'd0, if0.o_sel_valid}, 8'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Valid re-offered during a scan must not be captured.
        if1.i_data = 4'b1011; if1.i_valid = 1'b1;
        @(posedge clk); #1;
        if1.i_data = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        if1.i_valid = 1'b0;
        wait_idle();

        chk("end_q0_empty", 8'(q[0].size()), 8'd0);
        chk("end_q1_empty", 8'(q[1].size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
